// File: rtl/branch_chkpt_ctrl_pkg.sv
// Shared types and sizing for the branch checkpoint controller.
// Slot layout and recovery FSM encoding live here so rename/execute can reuse them.
package branch_chkpt_ctrl_pkg;

    localparam int PREGS       = 64;
    localparam int PREG_W      = 6;
    localparam int COUNT_W     = $clog2(PREGS) + 1;
    localparam int NUM_ARCH    = 32;
    localparam int MAP_W       = NUM_ARCH * PREG_W;
    localparam int NUM_CHKPT   = 4;
    localparam int CHKPT_TAG_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_RECOVER
    } chkpt_state_e;

    typedef struct packed {
        logic [MAP_W-1:0]   rat_map;
        logic [PREG_W-1:0]  fl_head;
        logic [COUNT_W-1:0] fl_count;
        logic [COUNT_W-1:0] free_since;
        logic               valid;
        logic               resolved;
    } chkpt_slot_t;

endpackage

// File: rtl/branch_chkpt_ctrl.sv
// Branch checkpoint queue: captures rename snapshots in program order, retires them
// on correct resolution, and replays the mispredicted branch's snapshot into rename.
module branch_chkpt_ctrl #(
    parameter int NUM_CHKPT = branch_chkpt_ctrl_pkg::NUM_CHKPT,
    parameter int TAG_W     = branch_chkpt_ctrl_pkg::CHKPT_TAG_W
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        chkpt_we_i,
    input  logic [branch_chkpt_ctrl_pkg::MAP_W-1:0]     chkpt_rat_map_i,
    input  logic [branch_chkpt_ctrl_pkg::PREG_W-1:0]    chkpt_fl_head_i,
    input  logic [branch_chkpt_ctrl_pkg::COUNT_W-1:0]   chkpt_fl_free_count_i,
    output logic [TAG_W-1:0]                            chkpt_tag_o,
    output logic                                        chkpt_avail_o,
    input  logic                                        commit_free_valid_i,
    input  logic [branch_chkpt_ctrl_pkg::PREG_W-1:0]    fl_live_tail_i,
    input  logic                                        resolve_valid_i,
    input  logic [TAG_W-1:0]                            resolve_tag_i,
    input  logic                                        resolve_mispredict_i,
    output logic                                        rat_recover_o,
    output logic [branch_chkpt_ctrl_pkg::MAP_W-1:0]     rat_recover_map_o,
    output logic                                        fl_recover_o,
    output logic [branch_chkpt_ctrl_pkg::PREG_W-1:0]    fl_recover_head_o,
    output logic [branch_chkpt_ctrl_pkg::PREG_W-1:0]    fl_recover_tail_o,
    output logic [branch_chkpt_ctrl_pkg::COUNT_W-1:0]   fl_recover_free_count_o,
    output logic                                        flush_o,
    output logic                                        busy_o
);
    import branch_chkpt_ctrl_pkg::*;

    localparam int PTR_W = $clog2(NUM_CHKPT);

    chkpt_slot_t        slots [NUM_CHKPT];
    logic [PTR_W-1:0]   oldest_q;
    logic [PTR_W-1:0]   alloc_q;
    logic [PTR_W-1:0]   rec_tag_q;
    chkpt_state_e       state_q;
    chkpt_state_e       state_d;

    logic               full;
    logic               tag_in_range;
    logic               tag_hit;
    logic               mispredict;
    logic               resolve_ok;
    logic               capture;
    logic               retire;
    logic [PTR_W-1:0]   res_idx;
    logic [PTR_W-1:0]   res_dist;
    logic [NUM_CHKPT-1:0] younger_mask;

    // Slots are contiguous from oldest_q, so the queue is full exactly when the alloc slot is occupied.
    assign full          = slots[alloc_q].valid;
    assign res_idx       = resolve_tag_i[PTR_W-1:0];
    assign tag_in_range  = {1'b0, resolve_tag_i} < (TAG_W+1)'(NUM_CHKPT);
    assign tag_hit       = resolve_valid_i && tag_in_range && slots[res_idx].valid
                           && (state_q == ST_IDLE);
    assign mispredict    = tag_hit && resolve_mispredict_i;
    assign resolve_ok    = tag_hit && !resolve_mispredict_i;
    assign chkpt_avail_o = !full && (state_q == ST_IDLE)
                           && !(resolve_valid_i && resolve_mispredict_i);
    assign capture       = chkpt_we_i && chkpt_avail_o;
    assign retire        = slots[oldest_q].valid && slots[oldest_q].resolved;
    assign res_dist      = res_idx - oldest_q;
    assign chkpt_tag_o   = TAG_W'(alloc_q);
    assign busy_o        = (state_q != ST_IDLE);

    always_comb begin
        younger_mask = '0;
        for (int i = 0; i < NUM_CHKPT; i++) begin
            younger_mask[i] = (PTR_W'(i) - oldest_q) >= res_dist;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            oldest_q  <= '0;
            alloc_q   <= '0;
            rec_tag_q <= '0;
            for (int i = 0; i < NUM_CHKPT; i++) begin
                slots[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_CHKPT; i++) begin
                if (commit_free_valid_i && slots[i].valid) begin
                    slots[i].free_since <= slots[i].free_since + 1'b1;
                end
            end
            if (retire) begin
                slots[oldest_q].valid <= 1'b0;
                oldest_q              <= oldest_q + 1'b1;
            end
            if (resolve_ok) begin
                slots[res_idx].resolved <= 1'b1;
            end
            if (capture) begin
                slots[alloc_q].rat_map    <= chkpt_rat_map_i;
                slots[alloc_q].fl_head    <= chkpt_fl_head_i;
                slots[alloc_q].fl_count   <= chkpt_fl_free_count_i;
                slots[alloc_q].free_since <= '0;
                slots[alloc_q].valid      <= 1'b1;
                slots[alloc_q].resolved   <= 1'b0;
                alloc_q                   <= alloc_q + 1'b1;
            end
            // The mispredicted slot keeps its snapshot data for the RECOVER cycle after going invalid.
            if (mispredict) begin
                for (int i = 0; i < NUM_CHKPT; i++) begin
                    if (younger_mask[i]) begin
                        slots[i].valid <= 1'b0;
                    end
                end
                alloc_q   <= res_idx;
                rec_tag_q <= res_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (mispredict) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rat_recover_o           = 1'b0;
        fl_recover_o            = 1'b0;
        flush_o                 = 1'b0;
        rat_recover_map_o       = '0;
        fl_recover_head_o       = '0;
        fl_recover_tail_o       = '0;
        fl_recover_free_count_o = '0;
        if (state_q == ST_RECOVER) begin
            rat_recover_o           = 1'b1;
            fl_recover_o            = 1'b1;
            flush_o                 = 1'b1;
            rat_recover_map_o       = slots[rec_tag_q].rat_map;
            fl_recover_head_o       = slots[rec_tag_q].fl_head;
            fl_recover_tail_o       = fl_live_tail_i;
            fl_recover_free_count_o = slots[rec_tag_q].fl_count + slots[rec_tag_q].free_since
                                      + COUNT_W'(commit_free_valid_i);
        end
    end

    // A capture squashed by a same-cycle mispredict is legal; anything else while stalled is not.
    chkpt_we_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
        chkpt_we_i |-> (!full && state_q == ST_IDLE));

endmodule

// File: tb/tb_branch_chkpt_ctrl.sv
// Bench for branch_chkpt_ctrl: directed scenarios plus randomized traffic checked
// against a program-order queue model of the checkpoints.
module tb_branch_chkpt_ctrl;

    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         chkpt_we_i;
    logic [191:0] chkpt_rat_map_i;
    logic [5:0]   chkpt_fl_head_i;
    logic [6:0]   chkpt_fl_free_count_i;
    logic [3:0]   chkpt_tag_o;
    logic         chkpt_avail_o;
    logic         commit_free_valid_i;
    logic [5:0]   fl_live_tail_i;
    logic         resolve_valid_i;
    logic [3:0]   resolve_tag_i;
    logic         resolve_mispredict_i;
    logic         rat_recover_o;
    logic [191:0] rat_recover_map_o;
    logic         fl_recover_o;
    logic [5:0]   fl_recover_head_o;
    logic [5:0]   fl_recover_tail_o;
    logic [6:0]   fl_recover_free_count_o;
    logic         flush_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_err = 0;

    branch_chkpt_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .chkpt_we_i(chkpt_we_i), .chkpt_rat_map_i(chkpt_rat_map_i),
        .chkpt_fl_head_i(chkpt_fl_head_i), .chkpt_fl_free_count_i(chkpt_fl_free_count_i),
        .chkpt_tag_o(chkpt_tag_o), .chkpt_avail_o(chkpt_avail_o),
        .commit_free_valid_i(commit_free_valid_i), .fl_live_tail_i(fl_live_tail_i),
        .resolve_valid_i(resolve_valid_i), .resolve_tag_i(resolve_tag_i),
        .resolve_mispredict_i(resolve_mispredict_i),
        .rat_recover_o(rat_recover_o), .rat_recover_map_o(rat_recover_map_o),
        .fl_recover_o(fl_recover_o), .fl_recover_head_o(fl_recover_head_o),
        .fl_recover_tail_o(fl_recover_tail_o), .fl_recover_free_count_o(fl_recover_free_count_o),
        .flush_o(flush_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: live checkpoints in program order, oldest first.
    typedef struct {
        int           tag;
        logic [191:0] map;
        logic [5:0]   head;
        logic [6:0]   cnt;
        logic [6:0]   fs;
        bit           resolved;
    } ent_t;

    ent_t mq[$];
    ent_t m_rent;
    bit   m_rec;
    int   m_alloc;

    function automatic logic [191:0] rand_map();
        logic [191:0] m;
        for (int w = 0; w < 6; w++) m[w*32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rec   = 0;
        m_alloc = 0;
    endfunction

    // Advances the model by one clock edge using the currently driven inputs.
    function automatic void model_update();
        bit   was_rec = m_rec;
        bit   pop     = (mq.size() > 0) && mq[0].resolved;
        bit   avail   = (mq.size() < N) && !was_rec && !(resolve_valid_i && resolve_mispredict_i);
        int   idx     = -1;
        ent_t e;
        if (!was_rec && resolve_valid_i)
            for (int i = 0; i < mq.size(); i++) if (mq[i].tag == int'(resolve_tag_i)) idx = i;
        if (commit_free_valid_i)
            for (int i = 0; i < mq.size(); i++) mq[i].fs = mq[i].fs + 7'd1;
        if (chkpt_we_i && avail) begin
            e.tag = m_alloc; e.map = chkpt_rat_map_i; e.head = chkpt_fl_head_i;
            e.cnt = chkpt_fl_free_count_i; e.fs = 7'd0; e.resolved = 0;
            mq.push_back(e);
            m_alloc = (m_alloc + 1) % N;
        end
        m_rec = 0;
        if (idx >= 0) begin
            if (!resolve_mispredict_i) mq[idx].resolved = 1;
            else begin
                m_rent = mq[idx];
                while (mq.size() > idx) void'(mq.pop_back());
                m_alloc = int'(resolve_tag_i);
                m_rec   = 1;
            end
        end
        if (pop) void'(mq.pop_front());
    endfunction

    task automatic clear_inputs();
        chkpt_we_i = 0; chkpt_rat_map_i = '0; chkpt_fl_head_i = '0; chkpt_fl_free_count_i = '0;
        commit_free_valid_i = 0; fl_live_tail_i = '0;
        resolve_valid_i = 0; resolve_tag_i = '0; resolve_mispredict_i = 0;
    endtask

    task automatic step();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic capture(input logic [5:0] head, input logic [6:0] cnt, input logic [191:0] map);
        clear_inputs();
        chkpt_we_i = 1; chkpt_fl_head_i = head; chkpt_fl_free_count_i = cnt; chkpt_rat_map_i = map;
        step();
        clear_inputs();
    endtask

    task automatic resolve(input int tag, input bit mis);
        clear_inputs();
        resolve_valid_i = 1; resolve_tag_i = 4'(tag); resolve_mispredict_i = mis;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        model_reset();
        #2;
        n_cmp++; if (chkpt_tag_o !== 4'd0) begin n_err++; $display("FAIL reset_tag: got %0d want 0", chkpt_tag_o); end
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL reset_avail: got %b want 1", chkpt_avail_o); end
        n_cmp++; if ({rat_recover_o, fl_recover_o, flush_o, busy_o} !== 4'b0)
            begin n_err++; $display("FAIL reset_recover: got %b want 0000", {rat_recover_o, fl_recover_o, flush_o, busy_o}); end
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < N; i++) begin
            clear_inputs();
            chkpt_we_i = 1; chkpt_fl_head_i = 6'($urandom); chkpt_rat_map_i = rand_map();
            #2;
            n_cmp++; if (chkpt_tag_o !== 4'(i)) begin n_err++; $display("FAIL fill_tag: got %0d want %0d", chkpt_tag_o, i); end
            step();
        end
        clear_inputs(); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b0) begin n_err++; $display("FAIL fill_full_avail: got %b want 0", chkpt_avail_o); end
        resolve(0, 0); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b0) begin n_err++; $display("FAIL fill_resolved_not_retired: got %b want 0", chkpt_avail_o); end
        step(); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL fill_retire_avail: got %b want 1", chkpt_avail_o); end
        n_cmp++; if (chkpt_tag_o !== 4'd0) begin n_err++; $display("FAIL fill_retire_tag: got %0d want 0", chkpt_tag_o); end
    endtask

    task automatic test_recover_count();
        logic [191:0] map1;
        map1 = rand_map();
        do_reset();
        capture(6'd5, 7'd10, rand_map());
        capture(6'd40, 7'd20, map1);
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); commit_free_valid_i = 1; step();
        end
        clear_inputs();
        resolve_valid_i = 1; resolve_tag_i = 4'd1; resolve_mispredict_i = 1;
        #2;
        n_cmp++; if (rat_recover_o !== 1'b0) begin n_err++; $display("FAIL rec_early_pulse: got %b want 0", rat_recover_o); end
        step();
        clear_inputs(); commit_free_valid_i = 1; fl_live_tail_i = 6'd12;
        #2;
        n_cmp++; if ({rat_recover_o, fl_recover_o, flush_o, busy_o} !== 4'b1111)
            begin n_err++; $display("FAIL rec_pulse: got %b want 1111", {rat_recover_o, fl_recover_o, flush_o, busy_o}); end
        n_cmp++; if (fl_recover_head_o !== 6'd40) begin n_err++; $display("FAIL rec_head: got %0d want 40", fl_recover_head_o); end
        n_cmp++; if (fl_recover_tail_o !== 6'd12) begin n_err++; $display("FAIL rec_tail: got %0d want 12", fl_recover_tail_o); end
        n_cmp++; if (fl_recover_free_count_o !== 7'd24) begin n_err++; $display("FAIL rec_count: got %0d want 24", fl_recover_free_count_o); end
        n_cmp++; if (rat_recover_map_o !== map1) begin n_err++; $display("FAIL rec_map: got %h want %h", rat_recover_map_o, map1); end
        step();
        clear_inputs(); #2;
        n_cmp++; if ({rat_recover_o, flush_o, busy_o} !== 3'b000)
            begin n_err++; $display("FAIL rec_one_shot: got %b want 000", {rat_recover_o, flush_o, busy_o}); end
        n_cmp++; if (chkpt_tag_o !== 4'd1) begin n_err++; $display("FAIL rec_next_tag: got %0d want 1", chkpt_tag_o); end
    endtask

    task automatic test_wrong_path_capture();
        do_reset();
        for (int i = 0; i < 3; i++) capture(6'($urandom), 7'($urandom), rand_map());
        clear_inputs();
        chkpt_we_i = 1; chkpt_rat_map_i = rand_map();
        resolve_valid_i = 1; resolve_tag_i = 4'd1; resolve_mispredict_i = 1;
        #2;
        n_cmp++; if (chkpt_avail_o !== 1'b0) begin n_err++; $display("FAIL wp_avail: got %b want 0", chkpt_avail_o); end
        step();
        clear_inputs();
        step();
        #2;
        n_cmp++; if (chkpt_tag_o !== 4'd1) begin n_err++; $display("FAIL wp_next_tag: got %0d want 1", chkpt_tag_o); end
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL wp_avail_after: got %b want 1", chkpt_avail_o); end
        resolve(2, 1);
        #2;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL wp_stale_tag2: busy got %b want 0", busy_o); end
    endtask

    task automatic test_ooo_resolve();
        do_reset();
        for (int i = 0; i < N; i++) capture(6'($urandom), 7'($urandom), rand_map());
        resolve(2, 0);
        resolve(0, 0);
        #2;
        n_cmp++; if (chkpt_avail_o !== 1'b0) begin n_err++; $display("FAIL ooo_before_retire: got %b want 0", chkpt_avail_o); end
        step(); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL ooo_tag0_retired: got %b want 1", chkpt_avail_o); end
        n_cmp++; if (chkpt_tag_o !== 4'd0) begin n_err++; $display("FAIL ooo_tag_after0: got %0d want 0", chkpt_tag_o); end
        capture(6'($urandom), 7'($urandom), rand_map());
        step(); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b0) begin n_err++; $display("FAIL ooo_tag1_blocks: got %b want 0", chkpt_avail_o); end
        resolve(1, 0);
        step(); #2;
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL ooo_tag1_retired: got %b want 1", chkpt_avail_o); end
        capture(6'($urandom), 7'($urandom), rand_map());
        #2;
        n_cmp++; if (chkpt_avail_o !== 1'b1) begin n_err++; $display("FAIL ooo_tag2_retired: got %b want 1", chkpt_avail_o); end
        n_cmp++; if (chkpt_tag_o !== 4'd2) begin n_err++; $display("FAIL ooo_final_tag: got %0d want 2", chkpt_tag_o); end
    endtask

    task automatic test_reset_mid_recover();
        do_reset();
        capture(6'd7, 7'd3, rand_map());
        resolve(0, 1);
        #2;
        n_cmp++; if (rat_recover_o !== 1'b1) begin n_err++; $display("FAIL rmr_in_recover: got %b want 1", rat_recover_o); end
        rst_i = 1;
        #1;
        n_cmp++; if ({rat_recover_o, fl_recover_o, flush_o, busy_o} !== 4'b0)
            begin n_err++; $display("FAIL rmr_async_drop: got %b want 0000", {rat_recover_o, fl_recover_o, flush_o, busy_o}); end
        n_cmp++; if ({chkpt_avail_o, chkpt_tag_o} !== 5'b1_0000)
            begin n_err++; $display("FAIL rmr_queue_empty: avail=%b tag=%0d want 1/0", chkpt_avail_o, chkpt_tag_o); end
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_random();
        bit  full, ok_avail;
        int  j, r;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            clear_inputs();
            full = (mq.size() == N);
            chkpt_we_i = (!full && !m_rec) ? ($urandom_range(0, 2) != 0) : 1'b0;
            chkpt_rat_map_i = rand_map();
            chkpt_fl_head_i = 6'($urandom);
            chkpt_fl_free_count_i = 7'($urandom);
            commit_free_valid_i = 1'($urandom);
            fl_live_tail_i = 6'($urandom);
            r = $urandom_range(0, 9);
            if (r < 4 && mq.size() > 0) begin
                j = $urandom_range(0, mq.size() - 1);
                if (!mq[j].resolved) begin
                    resolve_valid_i = 1; resolve_tag_i = 4'(mq[j].tag);
                    resolve_mispredict_i = ($urandom_range(0, 5) == 0);
                end
            end else if (r == 4) begin
                resolve_valid_i = 1; resolve_tag_i = 4'($urandom); resolve_mispredict_i = 1'($urandom);
                foreach (mq[k]) if (mq[k].tag == int'(resolve_tag_i) && mq[k].resolved) resolve_valid_i = 0;
            end
            #2;
            ok_avail = !full && !m_rec && !(resolve_valid_i && resolve_mispredict_i);
            n_cmp++; if (chkpt_tag_o !== 4'(m_alloc)) begin n_err++; $display("FAIL rnd_tag c%0d: got %0d want %0d", cyc, chkpt_tag_o, m_alloc); end
            n_cmp++; if (chkpt_avail_o !== ok_avail) begin n_err++; $display("FAIL rnd_avail c%0d: got %b want %b", cyc, chkpt_avail_o, ok_avail); end
            n_cmp++; if ({rat_recover_o, fl_recover_o, flush_o, busy_o} !== {4{m_rec}})
                begin n_err++; $display("FAIL rnd_ctrl c%0d: got %b want %b", cyc, {rat_recover_o, fl_recover_o, flush_o, busy_o}, {4{m_rec}}); end
            if (m_rec) begin
                n_cmp++; if (rat_recover_map_o !== m_rent.map) begin n_err++; $display("FAIL rnd_map c%0d: got %h want %h", cyc, rat_recover_map_o, m_rent.map); end
                n_cmp++; if (fl_recover_head_o !== m_rent.head) begin n_err++; $display("FAIL rnd_head c%0d: got %0d want %0d", cyc, fl_recover_head_o, m_rent.head); end
                n_cmp++; if (fl_recover_tail_o !== fl_live_tail_i) begin n_err++; $display("FAIL rnd_tail c%0d: got %0d want %0d", cyc, fl_recover_tail_o, fl_live_tail_i); end
                n_cmp++; if (fl_recover_free_count_o !== 7'(m_rent.cnt + m_rent.fs + 7'(commit_free_valid_i)))
                    begin n_err++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, fl_recover_free_count_o, 7'(m_rent.cnt + m_rent.fs + 7'(commit_free_valid_i))); end
            end else begin
                n_cmp++; if ({rat_recover_map_o, fl_recover_head_o, fl_recover_tail_o, fl_recover_free_count_o} !== '0)
                    begin n_err++; $display("FAIL rnd_idle_data c%0d: recover data not zero", cyc); end
            end
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_fill();
        test_recover_count();
        test_wrong_path_capture();
        test_ooo_resolve();
        test_reset_mid_recover();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
